vga_fb_arbiter: RTL

//  Shares one single-port framebuffer RAM between the VGA scan-out read path and NUM_REQ writers (game logic, text overlay, ...).

---
 rtl/vga_fb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads always win, writers share leftover
// slots round-robin (optionally only in vblank), plus a starved-frame counter.
module vga_fb_wr_lane (
  input  logic req,
  input  logic gnt,
  input  logic open,
  output logic elig
);
  // A writer granted this cycle sits out the next decision.
  assign elig = req & ~gnt & open;
endmodule

module vga_fb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 12,
  parameter bit VBLANK_ONLY = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  input  logic                      disp_req,
  input  logic [ADDR_W-1:0]         disp_addr,
  output logic [DATA_W-1:0]         disp_data,
  output logic                      disp_valid,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      frame_tick,
  output logic [7:0]                starve_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ACTIVE, BLANK} phase_t;

  phase_t                           phase;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   wrAddrArr;
  logic [NUM_REQ-1:0][DATA_W-1:0]   wrDataArr;
  logic [NUM_REQ-1:0]               elig;
  logic                             wrOpen;
  logic [PTR_W-1:0]                 rrPtr;
  logic [PTR_W-1:0]                 selIdx;
  logic [PTR_W:0]                   cand;
  logic                             found;
  logic [1:0]                       vldPipe;

  assign wrAddrArr = wr_addr;
  assign wrDataArr = wr_data;
  assign wrOpen    = (VBLANK_ONLY == 1'b0) || vblank;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : gLane
      vga_fb_wr_lane uLane (
        .req  (wr_req[g]),
        .gnt  (wr_gnt[g]),
        .open (wrOpen),
        .elig (elig[g])
      );
    end
  endgenerate

  // Scan from rrPtr+1 upward with wrap, first eligible writer wins.
  always_comb begin
    found  = 1'b0;
    selIdx = rrPtr;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rrPtr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && elig[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        selIdx = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_gnt    <= '0;
      rrPtr     <= PTR_W'(NUM_REQ - 1);
      vldPipe   <= '0;
    end else begin
      vldPipe <= {vldPipe[0], disp_req};
      wr_gnt  <= '0;
      if (disp_req) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end else if (found) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wrAddrArr[selIdx];
        mem_wdata <= wrDataArr[selIdx];
        wr_gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << selIdx;
        rrPtr     <= selIdx;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

  // RAM data arrives the cycle after mem_en; gate it so idle cycles read as 0.
  assign disp_valid = vldPipe[1];
  assign disp_data  = vldPipe[1] ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= ACTIVE;
      frame_tick <= 1'b0;
      starve_cnt <= '0;
    end else begin
      frame_tick <= 1'b0;
      case (phase)
        ACTIVE: if (vblank) begin
          phase      <= BLANK;
          frame_tick <= 1'b1;
        end
        BLANK: if (!vblank) begin
          phase <= ACTIVE;
          if (VBLANK_ONLY && (|wr_req) && (starve_cnt != 8'hFF))
            starve_cnt <= starve_cnt + 8'd1;
        end
        default: phase <= ACTIVE;
      endcase
    end
  end
endmodule
